// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache refill and LSU.
// Optional MEM_ARBITER_TIMEOUT_EN adds a wait-cycle watchdog with an err pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [1:0]            grant,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]   mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  i_valid_q, i_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic [1:0]            grant_q, grant_d;
    logic                  err_q, err_d;
    logic                  pick_i, pick_d;
    logic                  done, tmo;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        grant_d     = grant_q;
        err_d       = 1'b0;
        pick_i      = 1'b0;
        pick_d      = 1'b0;
        done        = 1'b0;
        tmo         = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // On a tie, last_d_q steers the grant to the other side.
                pick_i = i_req && (!d_req || last_d_q);
                pick_d = d_req && !pick_i;
                if (pick_i) begin
                    state_d     = SERVE_I;
                    last_d_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_wmask_d = '0;
                    grant_d     = 2'b01;
                end else if (pick_d) begin
                    state_d     = SERVE_D;
                    last_d_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wmask_d = d_wmask;
                    grant_d     = 2'b10;
                end
`ifdef MEM_ARBITER_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    done = 1'b1;
                end
`ifdef MEM_ARBITER_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    tmo = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (done || tmo) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    grant_d   = 2'b00;
                    err_d     = tmo;
                    if (state_q == SERVE_I) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = tmo ? '0 : mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = tmo ? '0 : mem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
            grant_q     <= 2'b00;
            err_q       <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
            grant_q     <= grant_d;
            err_q       <= err_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_valid   = i_valid_q;
    assign d_valid   = d_valid_q;
    assign grant     = grant_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a
// randomized round-robin run against a transaction-level model.
module tb_mem_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int TO_P = 4;
`else
    localparam int TO_P = 255;
`endif

    logic              CLK;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wmask;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [1:0]        grant;
    logic              err;

    int errs   = 0;
    int checks = 0;

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT(TO_P)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_valid(i_valid),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_wmask(d_wmask),
        .d_rdata(d_rdata),
        .d_valid(d_valid),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .grant(grant),
        .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic idle_inputs;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0) begin errs++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errs++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_wmask !== '0) begin errs++; $display("FAIL rst_mem_wmask got=%h exp=0", mem_wmask); end
        checks++; if (i_valid !== 1'b0) begin errs++; $display("FAIL rst_i_valid got=%b exp=0", i_valid); end
        checks++; if (d_valid !== 1'b0) begin errs++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
        checks++; if (i_rdata !== '0) begin errs++; $display("FAIL rst_i_rdata got=%h exp=0", i_rdata); end
        checks++; if (d_rdata !== '0) begin errs++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
        checks++; if (grant !== 2'b00) begin errs++; $display("FAIL rst_grant got=%b exp=00", grant); end
        checks++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err got=%b exp=0", err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_i_read;
        i_req = 1; i_addr = 20'h00400;
        tick();
        checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL ird_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 20'h00400) begin errs++; $display("FAIL ird_addr got=%h exp=00400", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL ird_we got=%b exp=0", mem_we); end
        checks++; if (mem_wmask !== 4'b0) begin errs++; $display("FAIL ird_wmask got=%b exp=0000", mem_wmask); end
        checks++; if (grant !== 2'b01) begin errs++; $display("FAIL ird_grant got=%b exp=01", grant); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || i_valid !== 1'b0) begin errs++; $display("FAIL ird_wait req=%b valid=%b exp=1/0", mem_req, i_valid); end
        end
        mem_ready = 1; mem_rdata = 32'h00B70023;
        tick();
        mem_ready = 0; mem_rdata = 32'h12345678; i_req = 0;
        checks++; if (i_valid !== 1'b1) begin errs++; $display("FAIL ird_valid got=%b exp=1", i_valid); end
        checks++; if (i_rdata !== 32'h00B70023) begin errs++; $display("FAIL ird_rdata got=%h exp=00b70023", i_rdata); end
        checks++; if (grant !== 2'b00) begin errs++; $display("FAIL ird_grant_done got=%b exp=00", grant); end
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL ird_req_drop got=%b exp=0", mem_req); end
        tick();
        checks++; if (i_valid !== 1'b0) begin errs++; $display("FAIL ird_pulse got=%b exp=0", i_valid); end
        checks++; if (i_rdata !== 32'h00B70023) begin errs++; $display("FAIL ird_hold got=%h exp=00b70023", i_rdata); end
    endtask

    task automatic test_d_write;
        d_req = 1; d_we = 1; d_addr = 20'h10010; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        tick();
        checks++; if (mem_we !== 1'b1) begin errs++; $display("FAIL dwr_we got=%b exp=1", mem_we); end
        checks++; if (mem_wmask !== 4'b0011) begin errs++; $display("FAIL dwr_wmask got=%b exp=0011", mem_wmask); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL dwr_wdata got=%h exp=deadbeef", mem_wdata); end
        checks++; if (mem_addr !== 20'h10010) begin errs++; $display("FAIL dwr_addr got=%h exp=10010", mem_addr); end
        checks++; if (grant !== 2'b10) begin errs++; $display("FAIL dwr_grant got=%b exp=10", grant); end
        tick();
        checks++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin errs++; $display("FAIL dwr_wait iv=%b dv=%b exp=0/0", i_valid, d_valid); end
        mem_ready = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ready = 0; d_req = 0;
        checks++; if (d_valid !== 1'b1) begin errs++; $display("FAIL dwr_valid got=%b exp=1", d_valid); end
        checks++; if (i_valid !== 1'b0) begin errs++; $display("FAIL dwr_ivalid got=%b exp=0", i_valid); end
        tick();
        checks++; if (d_valid !== 1'b0) begin errs++; $display("FAIL dwr_pulse got=%b exp=0", d_valid); end
    endtask

    task automatic test_back_to_back;
        logic [1:0]        g[4];
        int                cyc[4];
        int                n;
        logic              prev;
        logic [DATA_W-1:0] last_rd;
        do_reset();
        reset = 1'b1;
        i_req = 1; i_addr = 20'h00100;
        d_req = 1; d_we = 0; d_addr = 20'h20000; d_wmask = 4'hF;
        tick();
        reset = 1'b0;
        n = 0; prev = 1'b0; last_rd = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (mem_req && !prev) begin
                g[n] = grant; cyc[n] = c; n++;
            end
            if (i_valid) begin
                checks++; if (i_rdata !== last_rd) begin errs++; $display("FAIL b2b_irdata got=%h exp=%h", i_rdata, last_rd); end
            end
            if (d_valid) begin
                checks++; if (d_rdata !== last_rd) begin errs++; $display("FAIL b2b_drdata got=%h exp=%h", d_rdata, last_rd); end
            end
            prev = mem_req;
            mem_ready = mem_req;
            mem_rdata = $urandom;
            if (mem_ready) last_rd = mem_rdata;
            tick();
        end
        checks++; if (n != 4) begin errs++; $display("FAIL b2b_count got=%0d exp=4", n); end
        for (int k = 0; k < n; k++) begin
            checks++; if (g[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errs++; $display("FAIL b2b_order k=%0d got=%b exp=%b", k, g[k], (k % 2 == 0) ? 2'b01 : 2'b10); end
            if (k > 0) begin
                checks++; if (cyc[k] - cyc[k-1] != 3) begin errs++; $display("FAIL b2b_period k=%0d got=%0d exp=3", k, cyc[k] - cyc[k-1]); end
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid;
        do_reset();
        d_req = 1; d_we = 0; d_addr = 20'h0ABCD;
        tick();
        checks++; if (mem_req !== 1'b1 || grant !== 2'b10) begin errs++; $display("FAIL rmid_pre req=%b grant=%b exp=1/10", mem_req, grant); end
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rmid_req got=%b exp=0", mem_req); end
        checks++; if (grant !== 2'b00) begin errs++; $display("FAIL rmid_grant got=%b exp=00", grant); end
        checks++; if (d_valid !== 1'b0) begin errs++; $display("FAIL rmid_dvalid got=%b exp=0", d_valid); end
        tick();
        reset = 1'b0;
        i_req = 1; i_addr = 20'h00444;
        tick();
        checks++; if (grant !== 2'b01) begin errs++; $display("FAIL rmid_tie got=%b exp=01", grant); end
        checks++; if (mem_addr !== 20'h00444) begin errs++; $display("FAIL rmid_addr got=%h exp=00444", mem_addr); end
        do_reset();
    endtask

    task automatic test_idle_ready;
        do_reset();
        mem_ready = 1; mem_rdata = 32'hFFFF0000;
        tick();
        mem_ready = 0;
        checks++; if (i_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin errs++; $display("FAIL idlrdy_a iv=%b dv=%b req=%b exp=0/0/0", i_valid, d_valid, mem_req); end
        tick();
        checks++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin errs++; $display("FAIL idlrdy_b iv=%b dv=%b exp=0/0", i_valid, d_valid); end
        i_req = 1; i_addr = 20'h03000;
        tick();
        checks++; if (mem_addr !== 20'h03000) begin errs++; $display("FAIL latch_a got=%h exp=03000", mem_addr); end
        i_addr = 20'h0F0F0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (mem_addr !== 20'h03000) begin errs++; $display("FAIL latch_hold got=%h exp=03000", mem_addr); end
        end
        mem_ready = 1; mem_rdata = 32'hCAFE0001;
        tick();
        mem_ready = 0; i_req = 0;
        checks++; if (i_valid !== 1'b1 || i_rdata !== 32'hCAFE0001) begin errs++; $display("FAIL latch_done v=%b d=%h exp=1/cafe0001", i_valid, i_rdata); end
        tick();
    endtask

    task automatic test_timeout;
        int n;
        do_reset();
        i_req = 1; i_addr = 20'h00800;
        tick();
        mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_ready = 0; i_req = 0;
        checks++; if (i_rdata !== 32'h5A5A5A5A) begin errs++; $display("FAIL to_pre got=%h exp=5a5a5a5a", i_rdata); end
        tick();
        i_req = 1;
        tick();
        n = 0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 20 && mem_req; k++) begin
            n++;
            tick();
        end
        checks++; if (n != 4) begin errs++; $display("FAIL to_wait got=%0d exp=4", n); end
        checks++; if (err !== 1'b1 || i_valid !== 1'b1) begin errs++; $display("FAIL to_pulse err=%b iv=%b exp=1/1", err, i_valid); end
        checks++; if (i_rdata !== '0) begin errs++; $display("FAIL to_rdata got=%h exp=0", i_rdata); end
        i_req = 0;
        tick();
        checks++; if (err !== 1'b0) begin errs++; $display("FAIL to_errpulse got=%b exp=0", err); end
        i_req = 1;
        tick();
        repeat (3) tick();
        mem_ready = 1; mem_rdata = 32'h77778888;
        tick();
        mem_ready = 0; i_req = 0;
        checks++; if (err !== 1'b0 || i_valid !== 1'b1) begin errs++; $display("FAIL to_race err=%b iv=%b exp=0/1", err, i_valid); end
        checks++; if (i_rdata !== 32'h77778888) begin errs++; $display("FAIL to_race_rd got=%h exp=77778888", i_rdata); end
`else
        for (int k = 0; k < 20; k++) begin
            if (mem_req) n++;
            checks++; if (err !== 1'b0) begin errs++; $display("FAIL nto_err got=%b exp=0", err); end
            tick();
        end
        checks++; if (n != 20) begin errs++; $display("FAIL nto_wait got=%0d exp=20", n); end
        mem_ready = 1; mem_rdata = 32'h77778888;
        tick();
        mem_ready = 0; i_req = 0;
        checks++; if (i_valid !== 1'b1 || i_rdata !== 32'h77778888 || err !== 1'b0) begin errs++; $display("FAIL nto_done v=%b d=%h e=%b exp=1/77778888/0", i_valid, i_rdata, err); end
`endif
        tick();
    endtask

    task automatic test_random;
        logic              pend_i, pend_d, win_d, m_last_d;
        logic [ADDR_W-1:0] ia, da;
        logic              dwe;
        logic [DATA_W-1:0] dw, rd;
        logic [3:0]        dm;
        int                lat;
        do_reset();
        pend_i = 0; pend_d = 0; m_last_d = 1;
        ia = '0; da = '0; dwe = 0; dw = '0; dm = '0;
        for (int r = 0; r < 40; r++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; ia = ADDR_W'($urandom);
            end
            if (!pend_d && $urandom_range(0, 1) == 1) begin
                pend_d = 1; da = ADDR_W'($urandom); dwe = 1'($urandom);
                dw = $urandom; dm = 4'($urandom);
            end
            if (!pend_i && !pend_d) begin
                pend_i = 1; ia = ADDR_W'($urandom);
            end
            i_req = pend_i; i_addr = ia;
            d_req = pend_d; d_addr = da; d_we = dwe; d_wdata = dw; d_wmask = dm;
            win_d = (pend_i && pend_d) ? !m_last_d : pend_d;
            tick();
            checks++; if (grant !== (win_d ? 2'b10 : 2'b01)) begin errs++; $display("FAIL rnd_grant r=%0d got=%b exp=%b", r, grant, win_d ? 2'b10 : 2'b01); end
            checks++; if (mem_req !== 1'b1 || mem_addr !== (win_d ? da : ia)) begin errs++; $display("FAIL rnd_addr r=%0d req=%b got=%h exp=%h", r, mem_req, mem_addr, win_d ? da : ia); end
            checks++; if (mem_we !== (win_d ? dwe : 1'b0) || mem_wmask !== (win_d ? dm : 4'b0)) begin errs++; $display("FAIL rnd_we r=%0d we=%b mask=%b exp=%b/%b", r, mem_we, mem_wmask, win_d ? dwe : 1'b0, win_d ? dm : 4'b0); end
            if (win_d) begin
                checks++; if (mem_wdata !== dw) begin errs++; $display("FAIL rnd_wdata r=%0d got=%h exp=%h", r, mem_wdata, dw); end
            end
            lat = $urandom_range(0, 3);
            for (int k = 0; k < lat; k++) begin
                tick();
                checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rnd_hold r=%0d got=%b exp=1", r, mem_req); end
            end
            rd = $urandom;
            mem_ready = 1; mem_rdata = rd;
            tick();
            mem_ready = 0;
            checks++; if (i_valid !== !win_d || d_valid !== win_d) begin errs++; $display("FAIL rnd_valid r=%0d iv=%b dv=%b exp=%b/%b", r, i_valid, d_valid, !win_d, win_d); end
            checks++; if ((win_d ? d_rdata : i_rdata) !== rd) begin errs++; $display("FAIL rnd_rdata r=%0d got=%h exp=%h", r, win_d ? d_rdata : i_rdata, rd); end
            m_last_d = win_d;
            if (win_d) pend_d = 0;
            else pend_i = 0;
            i_req = pend_i; d_req = pend_d;
            tick();
            checks++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin errs++; $display("FAIL rnd_pulse r=%0d iv=%b dv=%b exp=0/0", r, i_valid, d_valid); end
        end
        do_reset();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_back_to_back();
        test_reset_mid();
        test_idle_ready();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one main-memory port between the instruction-cache refill path and the data (load/store) path.
- Round-robin arbitration; one outstanding transaction at a time; memory latency is variable.
- Refill side connects to the icache miss/fetch/write_data interface. Data side connects to the LSU. Memory side connects to the SPRAM/flash controller.

Parameters:
- ADDR_W, 20, byte address width (1MB space)
- DATA_W, 32, data word width
- TIMEOUT, 255, maximum cycles waiting for mem_ready (used only with the optional feature)

Ports:
- CLK  in  1  clock
- reset  in  1  asynchronous reset, active-high
- i_req  in  1  instruction refill request (level)
- i_addr  in  ADDR_W  refill address
- i_rdata  out  DATA_W  refill data
- i_valid  out  1  one-cycle pulse: i_rdata valid, transaction done
- d_req  in  1  data request (level)
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wmask  in  DATA_W/8  byte write enables
- d_rdata  out  DATA_W  read data
- d_valid  out  1  one-cycle pulse: d_rdata valid / write done
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, one cycle
- grant  out  2  00 none, 01 instruction, 10 data
- err  out  1  one-cycle timeout pulse

Behaviour:
- Reset (async, active-high):
  - State = IDLE; last_served = D, so instruction wins the first tie.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, i_valid, d_valid, i_rdata, d_rdata, grant, err.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - Only i_req -> SERVE_I. Only d_req -> SERVE_D.
  - Both asserted -> serve the requester not in last_served.
  - Neither -> stay in IDLE.
- On the grant edge:
  - Register the winner's address, and for the data path also we/wdata/wmask, into the mem_* outputs.
  - mem_req = 1; grant updated; last_served updated.
  - Instruction transactions always drive mem_we = 0 and mem_wmask = 0.
- SERVE_x: hold mem_req and all mem_* stable until a cycle with mem_ready = 1. In that cycle:
  - Capture mem_rdata into the x_rdata register.
  - Drop mem_req; go to DONE.
- DONE: assert x_valid for exactly one cycle; grant = 00; return to IDLE.
  - Requests sampled in DONE are ignored.
- Latency:
  - req seen in IDLE at cycle N -> mem_req = 1 at N+1.
  - mem_ready at cycle M -> x_valid = 1 at M+1.
  - Next grant decided at M+2; mem_req at M+3.
- Requesters hold req and payload stable until their valid pulse. Payload changes after the grant have no effect (it is latched).
- Requester drops req mid-transaction: the memory access still completes and the valid pulse is still issued.
- x_rdata holds its last value between transactions.
- For a data write, d_rdata captures mem_rdata anyway (don't-care content); d_valid still pulses.
- mem_ready asserted in IDLE or DONE: ignored.
- Back-to-back requests from both sides alternate strictly I, D, I, D.
- A single continuous requester is served every 3 cycles with zero-wait memory.

Optional Feature:
- Macro: MEM_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears on entering SERVE_x and increments each SERVE_x cycle without mem_ready.
  - On reaching TIMEOUT: drop mem_req, go to DONE, x_rdata = 0, x_valid pulses, err pulses in the same cycle as x_valid.
  - mem_ready in the same cycle as the counter reaching TIMEOUT wins: normal completion, no err.
- Not defined: no counter; SERVE_x waits indefinitely; err tied to 0.

Test Plan:
- i_req = 1, i_addr = 0x00400; mem_ready 2 cycles after mem_req with mem_rdata = 0x00B70023 -> mem_addr = 0x00400, mem_we = 0, i_valid one cycle with i_rdata = 0x00B70023, grant 01 -> 00.
- d_req = 1, d_we = 1, d_addr = 0x10010, d_wdata = 0xDEADBEEF, d_wmask = 0011 -> mem_we = 1, mem_wmask = 0011, mem_wdata = 0xDEADBEEF; d_valid pulses after mem_ready; i_valid stays 0.
- i_req and d_req both held from reset, zero-wait memory, 4 transactions -> grant order I, D, I, D; mem_req period 3 cycles.
- Reset asserted while in SERVE_D with mem_req = 1 -> mem_req, grant, d_valid go 0 immediately (async); after release, state IDLE and instruction wins the next tie.
- mem_ready pulsed while idle, then i_addr changed after grant -> no valid pulse from the idle pulse; mem_addr keeps the latched address.
- MEM_ARBITER_TIMEOUT_EN, TIMEOUT = 4, mem_ready never asserted -> mem_req drops after 4 wait cycles; err and i_valid pulse together; i_rdata = 0.
